// File: rtl/req_encoder.sv
// req_encoder
//   Turns a multi-hot request vector into a stream of binary indices,
//   one index per output handshake, lowest-numbered bit first.
//   A vector is accepted only while idle; its set bits are then emitted one
//   at a time. An all-zero vector produces no indices and raises a one-cycle
//   zero_err pulse instead.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   upstream vector valid
//   in_ready  out  block can accept a vector (idle)
//   in_vec    in   [N-1:0] request vector, bit i requests index i
//   out_valid out  out_idx is valid (emitting)
//   out_ready in   downstream accepts out_idx
//   out_idx   out  [IW-1:0] index of the lowest pending request
//   out_last  out  current index is the final one of the vector
//   zero_err  out  one-cycle pulse after an all-zero vector was accepted
module req_encoder #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          zero_err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [0:0]    state_q,    state_d;
   logic [N-1:0]  pending_q,  pending_d;
   logic          zero_err_q, zero_err_d;

   logic [IW-1:0] low_idx;
   logic          single;

   // Lowest set bit of the pending vector; scanning downward lets the
   // lowest index win.
   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) low_idx = IW'(i);
      end
   end

   // Exactly one bit left: clearing the lowest set bit leaves nothing.
   assign single = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

   // Outputs depend only on registered state.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_EMIT);
   assign out_idx   = (state_q == S_EMIT) ? low_idx : '0;
   assign out_last  = (state_q == S_EMIT) && single;
   assign zero_err  = zero_err_q;

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      zero_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               pending_d = in_vec;
               if (in_vec != '0) state_d    = S_EMIT;
               else              zero_err_d = 1'b1;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               pending_d = pending_q & ~(N'(1) << low_idx);
               if (single) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State update; reset wins over any handshake on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         zero_err_q <= zero_err_d;
      end
   end

endmodule

// File: doc/req_encoder.md
REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001 Parameter: N, default 4, request vector width; SHALL be a power of 2, >= 2.
REQ-002 Derived width: IW = log2(N), index width (2 at default).
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  upstream vector valid.
REQ-006 in_ready  out  1  block can accept a vector.
REQ-007 in_vec  in  N  multi-hot request vector; bit i requests index i.
REQ-008 out_valid  out  1  out_idx valid.
REQ-009 out_ready  in  1  downstream accepts out_idx.
REQ-010 out_idx  out  IW  binary index of the request being emitted.
REQ-011 out_last  out  1  current index is the final one of the accepted vector.
REQ-012 zero_err  out  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-013 Block SHALL be the inverse of the team's 2-to-4 decoder: it converts set bits of a vector into binary indices, one index per output handshake.
REQ-014 FSM SHALL have exactly two states: IDLE and EMIT.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in EMIT.
REQ-016 Input handshake = in_valid & in_ready at a rising edge; in_vec is captured into an N-bit pending register on that edge.
REQ-017 Captured vector non-zero -> next state EMIT. Captured vector zero -> stay IDLE, zero_err=1 for exactly the next cycle, no output produced.
REQ-018 In EMIT, out_idx SHALL equal the lowest-numbered set bit of pending. Priority is LSB-first.
REQ-019 out_last SHALL be 1 in EMIT iff pending has exactly one bit set.
REQ-020 Output handshake = out_valid & out_ready at a rising edge; that edge clears the pending bit at out_idx.
REQ-021 If out_last=1 at the output handshake, next state IDLE, and in_ready=1 in the following cycle.
REQ-022 Throughput: with out_ready held 1, a vector with k set bits SHALL yield k indices on k consecutive cycles, the first in the cycle after input acceptance.
REQ-023 While out_valid=1 and out_ready=0, out_idx, out_last and pending SHALL hold stable.
REQ-024 in_valid and in_vec SHALL be ignored in EMIT; no overlap or queuing of a second vector.
REQ-025 out_idx and out_last SHALL be 0 whenever out_valid=0.
REQ-026 All outputs SHALL be decoded from registered state only; there is no combinational path from in_* to out_*.

Reset
REQ-027 rst=1 at a rising edge -> state IDLE, pending=0, zero_err=0; this has priority over any handshake on the same edge.
REQ-028 Output values after the reset edge: in_ready=1, out_valid=0, out_idx=0, out_last=0, zero_err=0.
REQ-029 Reset mid-EMIT SHALL discard the remaining pending bits; no further indices are emitted.
REQ-030 While rst=1, in_valid SHALL NOT cause capture.

Verification (N=4)
REQ-031 Sparse vector: in_vec=4'b1010 accepted, out_ready=1 -> cycle+1: idx=1, last=0; cycle+2: idx=3, last=1; cycle+3: in_ready=1, out_valid=0.
REQ-032 Single bit: in_vec=4'b0001 -> one output, idx=0, last=1, then IDLE.
REQ-033 Backpressure: in_vec=4'b1111, out_ready pattern 1,0,0,1,0,1,1 -> indices 0,1,2,3 in order; idx and last stable during stalls; last=1 only on idx=3.
REQ-034 Zero vector: in_vec=4'b0000 accepted -> zero_err=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-035 Reset mid-operation: in_vec=4'b1110, rst=1 after idx=1 handshake -> next cycle out_valid=0, in_ready=1; indices 2 and 3 never appear.
REQ-036 Blocked input: in_valid=1 with in_vec=4'b0100 held during EMIT of 4'b0011 -> indices 0,1 emitted first; 4'b0100 accepted in the cycle after last=1; then idx=2.
